jpeg_pixel_mem_slave: RTL
=========================

JPEG_PIXEL_MEM_SLAVE -- requirements
Module: jpeg_pixel_mem_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 8, byte address width.
REQ-003 SHALL have parameter C_MEM_DEPTH, default 32, number of 32-bit words (power of 2, at most 2^(C_S_AXI_ADDR_WIDTH-2)).
REQ-004 S_AXI_ACLK  in  1  sole clock; all logic on rising edge.
REQ-005 S_AXI_ARESETN  in  1  reset; asynchronous, active-low.
REQ-006 S_AXI_AWADDR/AWPROT/AWVALID  in  ADDR/3/1; S_AXI_AWREADY  out  1  -- write address channel.
REQ-007 S_AXI_WDATA/WSTRB/WVALID  in  32/4/1; S_AXI_WREADY  out  1  -- write data channel.
REQ-008 S_AXI_BRESP/BVALID  out  2/1; S_AXI_BREADY  in  1  -- write response channel.
REQ-009 S_AXI_ARADDR/ARPROT/ARVALID  in  ADDR/3/1; S_AXI_ARREADY  out  1  -- read address channel.
REQ-010 S_AXI_RDATA/RRESP/RVALID  out  32/2/1; S_AXI_RREADY  in  1  -- read data channel.
REQ-011 FILL_DONE  out  1  one-cycle pulse when the word at index C_MEM_DEPTH-1 is written with OKAY.

Function
REQ-012 Write FSM SHALL have states W_IDLE, W_RESP; read FSM SHALL have states R_IDLE, R_DATA; the two operate independently.
REQ-013 In W_IDLE with AWVALID and WVALID both high, AWREADY and WREADY SHALL assert together for exactly one cycle; neither asserts while only one is valid.
REQ-014 On that handshake edge the memory word SHALL be updated per WSTRB byte lanes (WSTRB=0 writes nothing, still OKAY); FSM moves to W_RESP.
REQ-015 In W_RESP, BVALID SHALL be high with BRESP stable until the BVALID&BREADY edge, then return to W_IDLE; no new AW/W accepted meanwhile.
REQ-016 In R_IDLE with ARVALID, ARREADY SHALL assert for one cycle; RDATA/RRESP registered on that edge; FSM moves to R_DATA.
REQ-017 In R_DATA, RVALID SHALL be high with RDATA/RRESP stable until RVALID&RREADY edge, then return to R_IDLE.
REQ-018 Minimum latency: BVALID one cycle after AW/W handshake; RVALID one cycle after AR handshake; back-to-back throughput one transaction per 2 cycles per channel.
REQ-019 Word index SHALL be ADDR[log2(C_MEM_DEPTH)+1:2]; ADDR[1:0] ignored; AWPROT/ARPROT ignored.
REQ-020 Read and write handshakes on the same edge to the same index: read SHALL return pre-write data.
REQ-021 BRESP/RRESP SHALL be OKAY (2'b00) except per REQ-025.
REQ-022 FILL_DONE SHALL pulse on the cycle after the qualifying write handshake (aligned with BVALID rising).

Reset
REQ-023 While S_AXI_ARESETN low: AWREADY, WREADY, BVALID, ARREADY, RVALID, FILL_DONE = 0; BRESP, RRESP, RDATA = 0; FSMs in W_IDLE/R_IDLE.
REQ-024 Reset mid-transaction SHALL abort pending responses without completing them; memory contents are not cleared (undefined after power-up).

Configuration
REQ-025 With JPEG_PIXMEM_SLVERR_EN defined: address with any bit above index range nonzero SHALL get SLVERR (2'b10), no memory write, RDATA=0, no FILL_DONE; without it, upper bits ignored (index wraps) and response always OKAY.

Verification
REQ-026 Write 0x1,0x2,0x3,0x4 to 0x00,0x04,0x08,0x0C, read back same addresses -> RDATA 0x1..0x4, all RRESP OKAY.
REQ-027 Write 0xFFFFFFFF to 0x10, then 0x000000AB with WSTRB=4'b0001 -> read 0x10 returns 0xFFFFFFAB.
REQ-028 AWVALID high 3 cycles before WVALID; BREADY held low 5 cycles -> AWREADY/WREADY coincide with WVALID, BVALID held 5+ cycles, BRESP stable.
REQ-029 Write 0x55 to 0x80 (depth 32) -> with JPEG_PIXMEM_SLVERR_EN: BRESP=2'b10, read 0x00 unchanged, read 0x80 RRESP=2'b10 RDATA=0; without: 0x00 reads 0x55, OKAY.
REQ-030 Write 0x7C -> FILL_DONE high exactly one cycle, coincident with BVALID rising.
REQ-031 Assert S_AXI_ARESETN low while BVALID and RVALID high -> both drop asynchronously to 0; after release next transactions complete normally.

Source files
------------

// File: rtl/jpeg_pixel_mem_slave.sv
// AXI4-Lite slave backed by a C_MEM_DEPTH x 32-bit pixel word store, with a FILL_DONE pulse on the last word.
// Optional macro JPEG_PIXMEM_SLVERR_EN: out-of-range addresses get SLVERR instead of wrapping.
module jpeg_pixel_mem_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 8,
   parameter int C_MEM_DEPTH        = 32
) (
   input  logic                              S_AXI_ACLK,
   input  logic                              S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                        S_AXI_AWPROT,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                        S_AXI_ARPROT,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY,
   output logic                              FILL_DONE,
   output logic [0:0]                        w_state_dbg,
   output logic [0:0]                        r_state_dbg
);

   localparam int IDX_W = $clog2(C_MEM_DEPTH);
   localparam int LANES = C_S_AXI_DATA_WIDTH / 8;

   localparam logic [0:0] W_IDLE = 1'b0;
   localparam logic [0:0] W_RESP = 1'b1;
   localparam logic [0:0] R_IDLE = 1'b0;
   localparam logic [0:0] R_DATA = 1'b1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic [0:0]                      w_state;
   logic [0:0]                      r_state;
   logic                            w_hs;
   logic                            r_hs;
   logic                            w_err;
   logic                            r_err;
   logic [IDX_W-1:0]                w_idx;
   logic [IDX_W-1:0]                r_idx;
   logic [C_S_AXI_DATA_WIDTH-1:0]   mem [C_MEM_DEPTH];
   logic                            unused_bits;

   // Handshake (valid/ready): a channel transfers on a rising edge where both valid and ready are high.
   // Ready is combinational and gated by reset so it is low whenever reset is asserted.
   assign w_hs = S_AXI_ARESETN && (w_state == W_IDLE) && S_AXI_AWVALID && S_AXI_WVALID;
   assign r_hs = S_AXI_ARESETN && (r_state == R_IDLE) && S_AXI_ARVALID;

   assign S_AXI_AWREADY = w_hs;
   assign S_AXI_WREADY  = w_hs;
   assign S_AXI_ARREADY = r_hs;
   assign S_AXI_BVALID  = (w_state == W_RESP);
   assign S_AXI_RVALID  = (r_state == R_DATA);
   assign w_state_dbg   = w_state;
   assign r_state_dbg   = r_state;

   assign w_idx = S_AXI_AWADDR[IDX_W+1:2];
   assign r_idx = S_AXI_ARADDR[IDX_W+1:2];

`ifdef JPEG_PIXMEM_SLVERR_EN
   assign w_err = (S_AXI_AWADDR >> (IDX_W + 2)) != '0;
   assign r_err = (S_AXI_ARADDR >> (IDX_W + 2)) != '0;
`else
   assign w_err = 1'b0;
   assign r_err = 1'b0;
`endif

   // Protection bits and low address bits carry no meaning for this store.
   assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

   always_ff @(posedge S_AXI_ACLK) begin
      if (w_hs && !w_err) begin
         for (int b = 0; b < LANES; b++) begin
            if (S_AXI_WSTRB[b]) begin
               mem[w_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         w_state     <= W_IDLE;
         S_AXI_BRESP <= RESP_OKAY;
         FILL_DONE   <= 1'b0;
      end else begin
         FILL_DONE <= w_hs && !w_err && (w_idx == IDX_W'(C_MEM_DEPTH - 1));
         case (w_state)
            W_IDLE: begin
               if (w_hs) begin
                  w_state     <= W_RESP;
                  S_AXI_BRESP <= w_err ? RESP_SLVERR : RESP_OKAY;
               end
            end
            W_RESP: begin
               if (S_AXI_BREADY) begin
                  w_state <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // Read data is captured before any same-edge write lands, so a colliding read sees old data.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_state     <= R_IDLE;
         S_AXI_RDATA <= '0;
         S_AXI_RRESP <= RESP_OKAY;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (r_hs) begin
                  r_state     <= R_DATA;
                  S_AXI_RDATA <= r_err ? '0 : mem[r_idx];
                  S_AXI_RRESP <= r_err ? RESP_SLVERR : RESP_OKAY;
               end
            end
            R_DATA: begin
               if (S_AXI_RREADY) begin
                  r_state <= R_IDLE;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

endmodule
